// File: rtl/adder_acc_fifo.sv
// ---------------------------------------------------------------------------
// adder_acc_fifo
//
// Purpose:
//   Arithmetic front end with a result queue. Each accepted operand beat is
//   turned combinationally into a result (ADD, SUB, ACC or LOAD). The result
//   has optional unsigned saturation plus carry, signed-overflow and zero
//   flags. It is written into a DEPTH-entry circular FIFO at the accepting
//   edge. A valid/ready consumer drains the FIFO from its head.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   - The producer holds its payload stable while valid=1 and ready=0.
//   - ready never depends combinationally on valid.
//   - in_ready depends only on reset and the stored entry count, so there is
//     no combinational path from out_ready to in_ready.
//
// Ports:
//   clk        in   1      clock, all state updates on the rising edge
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block can accept a beat
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B (ignored for ACC and LOAD)
//   in_op      in   2      00 ADD, 01 SUB, 10 ACC, 11 LOAD
//   out_valid  out  1      FIFO head valid
//   out_ready  in   1      consumer takes the head
//   out_sum    out  WIDTH  head result
//   out_carry  out  1      head raw carry-out (SUB: 1 means a >= b)
//   out_ovf    out  1      head signed overflow of the raw operation
//   out_zero   out  1      head out_sum == 0 (after saturation)
//   acc_value  out  WIDTH  current accumulator register
//   op_count   out  CNT_W  accepted beats, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module adder_acc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [WIDTH-1:0] acc_value,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  // One FIFO entry: {sum, carry, ovf, zero}
  localparam int EW = WIDTH + 3;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [EW-1:0]    r_head;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_op_count;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  assign w_in_ready  = !reset && (r_count != CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready;

  // -------------------------------------------------------------------------
  // Datapath: a single WIDTH+1 adder covers ADD, SUB (a + ~b + 1) and ACC.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [WIDTH:0]   w_raw;
  logic             w_raw_ovf;

  assign w_x   = (in_op == OP_ACC) ? r_acc : in_a;
  assign w_y   = (in_op == OP_SUB) ? ~in_b :
                 (in_op == OP_ACC) ? in_a  : in_b;
  assign w_cin = (in_op == OP_SUB);
  assign w_raw = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

  // Two's-complement overflow: operands agree in sign, result does not.
  assign w_raw_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1]) &&
                     (w_raw[WIDTH-1] != w_x[WIDTH-1]);

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_ovf;
  logic             w_zero;
  logic [EW-1:0]    w_entry;

  always_comb begin
    w_sum   = w_raw[WIDTH-1:0];
    w_carry = w_raw[WIDTH];
    w_ovf   = w_raw_ovf;
    if (in_op == OP_LOAD) begin
      w_sum   = in_a;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
    end else if (SAT != 0) begin
      // Flags keep the raw carry/ovf; only the stored value is clamped.
      if (in_op == OP_SUB) begin
        if (!w_carry) w_sum = '0;
      end else if (w_carry) begin
        w_sum = '1;
      end
    end
    w_zero = (w_sum == '0);
  end

  assign w_entry = {w_sum, w_carry, w_ovf, w_zero};

  // -------------------------------------------------------------------------
  // FIFO bookkeeping
  // -------------------------------------------------------------------------
  logic [AW-1:0] w_rd_next;
  logic [CW-1:0] w_cnt_next;

  assign w_rd_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

  always_comb begin
    w_cnt_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_cnt_next = r_count + CW'(1);
      2'b01:   w_cnt_next = r_count - CW'(1);
      default: w_cnt_next = r_count;
    endcase
  end

  // Storage is not reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_acc      <= '0;
      r_op_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_cnt_next;

      // The output register tracks the entry that will be at the head after
      // this edge. The entry being written this cycle becomes the head only
      // when it lands in the slot the read pointer is moving to (FIFO empty,
      // or holding one entry that is being popped). When the FIFO drains,
      // the register keeps the last popped value.
      if (w_cnt_next != '0) begin
        if (w_push && (r_wr_ptr == w_rd_next)) r_head <= w_entry;
        else                                   r_head <= r_mem[w_rd_next];
      end

      if (w_push) begin
        r_op_count <= r_op_count + CNT_W'(1);
        if (in_op == OP_ACC)  r_acc <= w_sum;
        if (in_op == OP_LOAD) r_acc <= in_a;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_sum   = r_head[EW-1:3];
  assign out_carry = r_head[2];
  assign out_ovf   = r_head[1];
  assign out_zero  = r_head[0];
  assign acc_value = r_acc;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_adder_acc_fifo.sv
// ---------------------------------------------------------------------------
// tb_adder_acc_fifo
//
// Drives two instances (SAT=0 and SAT=1, WIDTH=8, DEPTH=4) with identical
// stimulus. Acceptance and draining depend only on the entry count, so both
// instances move in lockstep. An arithmetic reference model predicts each
// result, and a queue holds the expected FIFO contents.
// ---------------------------------------------------------------------------
module tb_adder_acc_fifo;

  localparam int W = 8;
  localparam int D = 4;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         out_ready;

  logic         in_ready  [2];
  logic         out_valid [2];
  logic [W-1:0] out_sum   [2];
  logic         out_carry [2];
  logic         out_ovf   [2];
  logic         out_zero  [2];
  logic [W-1:0] acc_value [2];
  logic [15:0]  op_count  [2];

  adder_acc_fifo #(.WIDTH(W), .DEPTH(D), .SAT(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_sum(out_sum[0]), .out_carry(out_carry[0]),
    .out_ovf(out_ovf[0]), .out_zero(out_zero[0]), .acc_value(acc_value[0]),
    .op_count(op_count[0])
  );

  adder_acc_fifo #(.WIDTH(W), .DEPTH(D), .SAT(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_sum(out_sum[1]), .out_carry(out_carry[1]),
    .out_ovf(out_ovf[1]), .out_zero(out_zero[1]), .acc_value(acc_value[1]),
    .op_count(op_count[1])
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  // Each queue entry is {entry_sat1, entry_sat0}; entry = {sum, carry, ovf, zero}
  logic [21:0]  exp_q[$];
  logic [10:0]  m_last [2];
  logic [W-1:0] m_acc  [2];
  logic [15:0]  m_cnt;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation rules.
  function automatic void model(input int sat, input logic [1:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] acc,
                                output logic [10:0] ent,
                                output logic [W-1:0] nacc);
    int x, y, s, sx, sy, ss, res;
    bit c, v;
    x  = (op == 2'd2) ? int'(acc) : int'(a);
    y  = (op == 2'd2) ? int'(a)   : int'(b);
    sx = (x > 127) ? x - 256 : x;
    sy = (y > 127) ? y - 256 : y;
    case (op)
      2'd0, 2'd2: begin
        s   = x + y;
        c   = (s > 255);
        ss  = sx + sy;
        v   = (ss > 127) || (ss < -128);
        res = (sat != 0 && c) ? 255 : s % 256;
      end
      2'd1: begin
        s   = x - y;
        c   = (x >= y);
        ss  = sx - sy;
        v   = (ss > 127) || (ss < -128);
        res = (sat != 0 && !c) ? 0 : (s + 256) % 256;
      end
      default: begin
        res = int'(a);
        c   = 1'b0;
        v   = 1'b0;
      end
    endcase
    ent  = {res[7:0], c, v, (res == 0)};
    nacc = (op == 2'd2) ? res[7:0] : (op == 2'd3) ? a : acc;
  endfunction

  // Compare observable state against the model, then apply this edge's
  // push/pop/reset to the model.
  task automatic check_cycle();
    int          sz;
    logic [21:0] hd;
    logic [10:0] e0, e1, exp_head;
    logic [W-1:0] na0, na1;
    sz = exp_q.size();
    if (reset) begin
      for (int k = 0; k < 2; k++) check("in_ready_in_reset", in_ready[k], 0);
      exp_q.delete();
      m_last[0] = '0; m_last[1] = '0;
      m_acc[0]  = '0; m_acc[1]  = '0;
      m_cnt     = '0;
      return;
    end
    hd = (sz != 0) ? exp_q[0] : 22'd0;
    for (int k = 0; k < 2; k++) begin
      check("out_valid", out_valid[k], (sz != 0));
      check("in_ready", in_ready[k], (sz != D));
      check("acc_value", acc_value[k], m_acc[k]);
      check("op_count", op_count[k], m_cnt);
      exp_head = (sz != 0) ? hd[k*11 +: 11] : m_last[k];
      check(k == 0 ? "head_sat0" : "head_sat1",
            {out_sum[k], out_carry[k], out_ovf[k], out_zero[k]}, exp_head);
    end
    if (sz != 0 && out_ready) begin
      hd = exp_q.pop_front();
      m_last[0] = hd[10:0];
      m_last[1] = hd[21:11];
    end
    if (in_valid && sz != D) begin
      model(0, in_op, in_a, in_b, m_acc[0], e0, na0);
      model(1, in_op, in_a, in_b, m_acc[1], e1, na1);
      m_acc[0] = na0;
      m_acc[1] = na1;
      exp_q.push_back({e1, e0});
      m_cnt++;
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver
  // -------------------------------------------------------------------------
  task automatic step(input logic v, input logic [1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic rdy, input logic rst);
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    reset     = rst;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, '0, rdy, 1'b0);
  endtask

  initial begin
    m_last[0] = '0; m_last[1] = '0;
    m_acc[0]  = '0; m_acc[1]  = '0;
    m_cnt     = '0;

    // Reset, then reset-state checks on the first idle cycle
    step(1'b0, 2'd0, '0, '0, 1'b0, 1'b1);
    step(1'b0, 2'd0, '0, '0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Directed arithmetic cases: carry, borrow, overflow, zero
    step(1'b1, 2'd0, 8'd200, 8'd100, 1'b1, 1'b0);
    step(1'b1, 2'd1, 8'd5,   8'd7,   1'b1, 1'b0);
    step(1'b1, 2'd0, 8'd127, 8'd1,   1'b1, 1'b0);
    step(1'b1, 2'd0, 8'd128, 8'd128, 1'b1, 1'b0);
    step(1'b1, 2'd1, 8'd9,   8'd9,   1'b1, 1'b0);
    idle(3, 1'b1);

    // LOAD/ACC chain back-to-back
    step(1'b1, 2'd3, 8'd10, 8'd0, 1'b1, 1'b0);
    step(1'b1, 2'd2, 8'd20, 8'd0, 1'b1, 1'b0);
    step(1'b1, 2'd2, 8'd30, 8'd0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Fill to full with the consumer stalled, then drain
    for (int i = 0; i < 6; i++) step(1'b1, 2'd0, 8'd1, W'(i), 1'b0, 1'b0);
    idle(6, 1'b1);

    // Reset with three entries queued
    step(1'b1, 2'd3, 8'd10, 8'd0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 8'd20, 8'd0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 8'd30, 8'd0, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 2'd0, '0, '0, 1'b0, 1'b1);
    idle(1, 1'b1);
    step(1'b1, 2'd0, 8'd3, 8'd4, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0));
    end
    idle(6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_acc_fifo.md
Name: adder_acc_fifo

Overview:
- Parametrised successor to the 4-bit combinational adder core.
- Accepts operand pairs over a valid/ready handshake and performs one of four operations: add, subtract, accumulate, load.
- Optionally saturates results; produces carry, signed-overflow and zero flags.
- Queues results in a DEPTH-entry output FIFO drained by a valid/ready consumer. Sits between the pin-level wrapper and downstream result logic.

Parameters:
- WIDTH, 8: operand/result width in bits, >= 2.
- DEPTH, 4: result FIFO entries, power of 2, >= 2.
- SAT, 0: 1 = unsigned saturation on ADD/SUB/ACC; 0 = modulo wrap.
- CNT_W, 16: width of accepted-operation counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B (ignored for ACC and LOAD).
- in_op  in  2  00 ADD, 01 SUB, 10 ACC, 11 LOAD.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_sum  out  WIDTH  head result.
- out_carry  out  1  head raw carry-out (SUB: 1 = no borrow, i.e. a >= b).
- out_ovf  out  1  head signed two's-complement overflow of the raw op.
- out_zero  out  1  head out_sum == 0 (after saturation).
- acc_value  out  WIDTH  current accumulator register.
- op_count  out  CNT_W  number of accepted beats, wraps modulo 2^CNT_W.

Behaviour:
- Reset is synchronous and active-high: while reset is high at a clock edge, FIFO count and pointers, acc_value and op_count are cleared to 0. in_ready is forced 0 while reset is high.
- After reset: out_valid=0, out_sum/out_carry/out_ovf/out_zero=0, in_ready=1.
- Reset mid-operation discards all queued results; no partial state survives.
- Accept: the beat is accepted on a cycle with in_valid && in_ready. in_ready = !reset && (count != DEPTH). There is no full-bypass: when full, a same-cycle pop does not raise in_ready.
- Latency:
  - The result is computed combinationally from the accepted beat and written into the FIFO at that edge.
  - out_valid rises the cycle after acceptance if the FIFO was empty.
- Op semantics (raw = WIDTH+1 bit result):
  - ADD: raw = a + b.
  - SUB: raw = a + ~b + 1.
  - ACC: raw = acc_value + a; acc_value <= stored result.
  - LOAD: result = a, carry=0, ovf=0; acc_value <= a.
- Signed overflow is computed on the WIDTH-bit operands of the raw op (for ACC, the operands are acc_value and a).
- SAT=1:
  - ADD/ACC with carry=1 -> result all-ones.
  - SUB with carry=0 (borrow) -> result 0.
  - Flags still report the raw carry and ovf; zero reflects the saturated result.
- SAT=0: result = raw[WIDTH-1:0].
- ADD/SUB leave acc_value unchanged.
- op_count increments by 1 per accepted beat, wrapping to 0.
- FIFO:
  - Circular, pointers wrap at DEPTH.
  - out_* always present the head entry; out_* hold their values while out_valid=1 and out_ready=0.
  - A pop occurs on out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push when empty with no pop: count 0 -> 1.
  - Pop on the last entry: out_valid falls the next cycle unless a push happened the same cycle.
  - Ordering is strictly FIFO.
- out_* hold their last values when empty, except directly after reset, when they are 0.
- No internal combinational path from out_ready to in_ready.

Test Plan:
- WIDTH=8, SAT=0, ADD a=200 b=100 -> out_sum=44, carry=1, ovf=0, zero=0. With SAT=1 -> out_sum=255, carry=1.
- SUB a=5 b=7 -> SAT=0: out_sum=254, carry=0, ovf=0. SAT=1: out_sum=0, zero=1.
- LOAD a=10, ACC a=20, ACC a=30 back-to-back, out_ready=1 -> results 10, 30, 60 on consecutive cycles starting one cycle after the first accept; acc_value=60; op_count=3.
- DEPTH=4, out_ready=0, in_valid=1 for 6 cycles with ADD 1+i:
  - Exactly 4 beats accepted; in_ready=0 after the 4th; op_count=4.
  - Then out_ready=1: 4 results drain in order, one per cycle; in_ready returns to 1 one cycle after the first pop.
- Edge cases: ADD 127+1 -> out_sum=128, ovf=1, carry=0. ADD 128+128 -> out_sum=0, zero=1, carry=1, ovf=1.
- Reset mid-stream:
  - With 3 entries queued and acc_value=60, assert reset for 1 cycle -> next cycle out_valid=0, acc_value=0, op_count=0, in_ready=1.
  - A following ADD 3+4 -> single result 7.
